fp_multiplier_pipe: RTL and testbench

Parametrised, pipelined IEEE-754-style floating-point multiplier with valid/ready flow control, round-to-nearest-even, special-value handling and exception flags. It supersedes the single-cycle combinational FP multiplier in the arithmetic datapath: it is configurable for any exponent and mantissa width and sustains one result per clock when the consumer does not stall.

---
 rtl/fp_multiplier_pipe.sv | 182 ++++++++++++++++++
 tb/tb_fp_multiplier_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_multiplier_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow control.
// Subnormals read as zero, results round to nearest even, and underflow flushes to zero.
module fp_multiplier_pipe #(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 23,
  parameter int DATA_WIDTH = 1 + EXP_WIDTH + MANT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] dataA_i,
  input  logic [DATA_WIDTH-1:0] dataB_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [2:0]            flags_o
);
  localparam int E  = EXP_WIDTH;
  localparam int M  = MANT_WIDTH;
  localparam int XW = E + 2;
  localparam logic [E-1:0]           EMAX   = '1;
  localparam logic signed [XW-1:0]   BIAS   = XW'((1 << (E - 1)) - 1);
  localparam logic signed [XW-1:0]   EMAX_X = XW'((1 << E) - 1);
  localparam logic [DATA_WIDTH-1:0]  QNAN   = {1'b0, EMAX, 1'b1, {(M-1){1'b0}}};

  logic adv;
  logic s1_valid_q, s2_valid_q, s3_valid_q;

  assign adv     = !s3_valid_q | ready_i;
  assign ready_o = adv;
  assign valid_o = s3_valid_q;

  // Stage 1: unpack, classify, exponent sum, special-case decision
  logic          sign_a, sign_b;
  logic [E-1:0]  exp_a, exp_b;
  logic [M-1:0]  frac_a, frac_b;
  logic          zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, inv_op;

  assign {sign_a, exp_a, frac_a} = dataA_i;
  assign {sign_b, exp_b, frac_b} = dataB_i;
  assign zero_a = (exp_a == '0);
  assign zero_b = (exp_b == '0);
  assign inf_a  = (exp_a == EMAX) && (frac_a == '0);
  assign inf_b  = (exp_b == EMAX) && (frac_b == '0);
  assign nan_a  = (exp_a == EMAX) && (frac_a != '0);
  assign nan_b  = (exp_b == EMAX) && (frac_b != '0);
  assign inv_op = (inf_a & zero_b) | (zero_a & inf_b);

  logic                   s1_sign_d, s1_special_d;
  logic [DATA_WIDTH-1:0]  s1_spec_data_d;
  logic [2:0]             s1_spec_flags_d;
  logic signed [XW-1:0]   s1_exp_d;

  always_comb begin
    s1_sign_d       = sign_a ^ sign_b;
    s1_special_d    = 1'b1;
    s1_spec_data_d  = '0;
    s1_spec_flags_d = '0;
    s1_exp_d        = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS;
    if (nan_a | nan_b | inv_op) begin
      s1_spec_data_d  = QNAN;
      s1_spec_flags_d = {inv_op, 2'b00};
    end else if (inf_a | inf_b) begin
      s1_spec_data_d = {s1_sign_d, EMAX, {M{1'b0}}};
    end else if (zero_a | zero_b) begin
      s1_spec_data_d = {s1_sign_d, {(E+M){1'b0}}};
    end else begin
      s1_special_d = 1'b0;
    end
  end

  logic                   s1_sign_q, s1_special_q;
  logic [DATA_WIDTH-1:0]  s1_spec_data_q;
  logic [2:0]             s1_spec_flags_q;
  logic signed [XW-1:0]   s1_exp_q;
  logic [M:0]             s1_sig_a_q, s1_sig_b_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q      <= 1'b0;
      s1_sign_q       <= 1'b0;
      s1_special_q    <= 1'b0;
      s1_spec_data_q  <= '0;
      s1_spec_flags_q <= '0;
      s1_exp_q        <= '0;
      s1_sig_a_q      <= '0;
      s1_sig_b_q      <= '0;
    end else if (adv) begin
      s1_valid_q      <= valid_i & ready_o;
      s1_sign_q       <= s1_sign_d;
      s1_special_q    <= s1_special_d;
      s1_spec_data_q  <= s1_spec_data_d;
      s1_spec_flags_q <= s1_spec_flags_d;
      s1_exp_q        <= s1_exp_d;
      s1_sig_a_q      <= {1'b1, frac_a};
      s1_sig_b_q      <= {1'b1, frac_b};
    end
  end

  // Stage 2: significand multiply
  logic [2*M+1:0]         s2_prod_d, s2_prod_q;
  logic                   s2_sign_q, s2_special_q;
  logic [DATA_WIDTH-1:0]  s2_spec_data_q;
  logic [2:0]             s2_spec_flags_q;
  logic signed [XW-1:0]   s2_exp_q;

  assign s2_prod_d = {{(M+1){1'b0}}, s1_sig_a_q} * {{(M+1){1'b0}}, s1_sig_b_q};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_valid_q      <= 1'b0;
      s2_sign_q       <= 1'b0;
      s2_special_q    <= 1'b0;
      s2_spec_data_q  <= '0;
      s2_spec_flags_q <= '0;
      s2_exp_q        <= '0;
      s2_prod_q       <= '0;
    end else if (adv) begin
      s2_valid_q      <= s1_valid_q;
      s2_sign_q       <= s1_sign_q;
      s2_special_q    <= s1_special_q;
      s2_spec_data_q  <= s1_spec_data_q;
      s2_spec_flags_q <= s1_spec_flags_q;
      s2_exp_q        <= s1_exp_q;
      s2_prod_q       <= s2_prod_d;
    end
  end

  // Stage 3: normalise, round, pack, flags
  logic [2*M+1:0]        shifted;
  logic [M:0]            norm;
  logic [M+1:0]          rounded;
  logic [M-1:0]          frac_fin;
  logic                  guard, rnd, sticky;
  logic signed [XW-1:0]  exp_fin;
  logic [DATA_WIDTH-1:0] s3_data_d, s3_data_q;
  logic [2:0]            s3_flags_d, s3_flags_q;

  always_comb begin
    shifted  = s2_prod_q[2*M+1] ? s2_prod_q : {s2_prod_q[2*M:0], 1'b0};
    norm     = shifted[2*M+1:M+1];
    guard    = shifted[M];
    rnd      = shifted[M-1];
    sticky   = |shifted[M-2:0];
    rounded  = {1'b0, norm} + {{(M+1){1'b0}}, guard & (rnd | sticky | norm[0])};
    // A rounding carry leaves exactly 10...0, so the fraction comes out zero
    frac_fin = rounded[M+1] ? rounded[M:1] : rounded[M-1:0];
    exp_fin  = s2_exp_q + {{(XW-1){1'b0}}, s2_prod_q[2*M+1]} + {{(XW-1){1'b0}}, rounded[M+1]};
    s3_data_d  = '0;
    s3_flags_d = '0;
    if (s2_valid_q) begin
      if (s2_special_q) begin
        s3_data_d  = s2_spec_data_q;
        s3_flags_d = s2_spec_flags_q;
      end else if (exp_fin >= EMAX_X) begin
        s3_data_d  = {s2_sign_q, EMAX, {M{1'b0}}};
        s3_flags_d = 3'b010;
      end else if (exp_fin[XW-1] || (exp_fin == '0)) begin
        s3_data_d  = {s2_sign_q, {(E+M){1'b0}}};
        s3_flags_d = 3'b001;
      end else begin
        s3_data_d  = {s2_sign_q, exp_fin[E-1:0], frac_fin};
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s3_valid_q <= 1'b0;
      s3_data_q  <= '0;
      s3_flags_q <= '0;
    end else if (adv) begin
      s3_valid_q <= s2_valid_q;
      s3_data_q  <= s3_data_d;
      s3_flags_q <= s3_flags_d;
    end
  end

  assign data_o  = s3_data_q;
  assign flags_o = s3_flags_q;
endmodule

// File: tb/tb_fp_multiplier_pipe.sv
// Directed-vector bench for fp_multiplier_pipe: single and half precision instances,
// streaming, backpressure and reset-in-flight with an expected-result queue.
module tb_fp_multiplier_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_i = 1'b0, ready_i = 1'b1;
  logic [31:0] a_i = '0, b_i = '0;
  logic        ready_o, valid_o;
  logic [31:0] data_o;
  logic [2:0]  flags_o;

  logic        vh_i = 1'b0, rdy_h_i = 1'b1;
  logic [15:0] ah_i = '0, bh_i = '0;
  logic        rdy_h_o, vh_o;
  logic [15:0] dh_o;
  logic [2:0]  fh_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] exp_d = '0;
  logic [2:0]  expf_d = '0;
  logic [31:0] exp_q[$];
  logic [2:0]  expf_q[$];
  int          acc_q[$];
  logic        lat_chk = 1'b0, bp_chk = 1'b0, stalled = 1'b0;
  logic [31:0] held = '0;

  always #5 clk = ~clk;

  fp_multiplier_pipe dut32 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
    .dataA_i(a_i), .dataB_i(b_i), .valid_o(valid_o), .ready_i(ready_i),
    .data_o(data_o), .flags_o(flags_o)
  );

  fp_multiplier_pipe #(.EXP_WIDTH(5), .MANT_WIDTH(10)) dut16 (
    .clk_i(clk), .rst_i(rst), .valid_i(vh_i), .ready_o(rdy_h_o),
    .dataA_i(ah_i), .dataB_i(bh_i), .valid_o(vh_o), .ready_i(rdy_h_i),
    .data_o(dh_o), .flags_o(fh_o)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // cyc is bumped before the accept is recorded, so a result due after
  // accept edge N+2 is seen with cyc - label == 2
  always @(posedge clk) begin
    cyc++;
    if (!rst && valid_i && ready_o) begin
      exp_q.push_back(exp_d);
      expf_q.push_back(expf_d);
      acc_q.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    logic [31:0] ed;
    logic [2:0]  ef;
    int          ac;
    #2;
    if (!rst) begin
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          check_val("spurious_result", {32'd0, data_o}, 64'hDEAD);
        end else begin
          ed = exp_q.pop_front();
          ef = expf_q.pop_front();
          ac = acc_q.pop_front();
          check_val("data", {32'd0, data_o}, {32'd0, ed});
          check_val("flags", {61'd0, flags_o}, {61'd0, ef});
          if (lat_chk) check_val("latency", 64'(cyc - ac), 64'd2);
        end
      end
      if (valid_o && !ready_i) begin
        check_val("stall_ready", {63'd0, ready_o}, 64'd0);
        if (stalled) check_val("stall_hold", {32'd0, data_o}, {32'd0, held});
        held    = data_o;
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
        if (bp_chk) check_val("ready_high", {63'd0, ready_o}, 64'd1);
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ed, input logic [2:0] ef);
    int n;
    @(negedge clk);
    valid_i = 1'b1;
    a_i = a;
    b_i = b;
    exp_d = ed;
    expf_d = ef;
    n = 0;
    #1;
    while (!ready_o && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_val("accept", {63'd0, ready_o}, 64'd1);
    @(posedge clk);
  endtask

  task automatic drain();
    int n;
    @(negedge clk);
    valid_i = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check_val("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic send_half(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] ed, input logic [2:0] ef);
    @(negedge clk);
    vh_i = 1'b1;
    ah_i = a;
    bh_i = b;
    @(posedge clk);
    @(negedge clk);
    vh_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("h_valid", {63'd0, vh_o}, 64'd1);
    check_val("h_data", {48'd0, dh_o}, {48'd0, ed});
    check_val("h_flags", {61'd0, fh_o}, {61'd0, ef});
  endtask

  logic [31:0] va[12] = '{32'h3FC00000, 32'h3F800000, 32'h3F800001, 32'h3F800800,
                          32'h7F800000, 32'hFF800000, 32'h7FC00001, 32'h7F000000,
                          32'h00800000, 32'h3FC00001, 32'hBFC00000, 32'h3FFFFFFF};
  logic [31:0] vb[12] = '{32'h40000000, 32'h3F800000, 32'h3F800001, 32'h3F800800,
                          32'h00000000, 32'h40000000, 32'h3F800000, 32'h40000000,
                          32'h3F000000, 32'h3FC00001, 32'h40000000, 32'h3F800001};
  logic [31:0] vr[12] = '{32'h40400000, 32'h3F800000, 32'h3F800002, 32'h3F801000,
                          32'h7FC00000, 32'hFF800000, 32'h7FC00000, 32'h7F800000,
                          32'h00000000, 32'h40100002, 32'hC0400000, 32'h40000000};
  logic [2:0]  vf[12] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000,
                          3'b000, 3'b010, 3'b001, 3'b000, 3'b000, 3'b000};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    check_val("rst_valid", {63'd0, valid_o}, 64'd0);
    check_val("rst_data", {32'd0, data_o}, 64'd0);
    check_val("rst_flags", {61'd0, flags_o}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_ready", {63'd0, ready_o}, 64'd1);

    // back-to-back stream, one accept per cycle
    lat_chk = 1'b1;
    for (int i = 0; i < 12; i++) send(va[i], vb[i], vr[i], vf[i]);
    drain();
    lat_chk = 1'b0;

    // six pairs with a four-cycle consumer stall mid-stream
    bp_chk = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++) send(va[i], vb[i], vr[i], vf[i]);
      end
      begin
        repeat (3) @(negedge clk);
        ready_i = 1'b0;
        repeat (4) @(negedge clk);
        ready_i = 1'b1;
      end
    join
    drain();
    bp_chk = 1'b0;

    // reset with two transactions in flight
    send(va[0], vb[0], vr[0], vf[0]);
    send(va[1], vb[1], vr[1], vf[1]);
    @(negedge clk);
    valid_i = 1'b0;
    @(posedge clk);
    #2;
    check_val("pre_rst_valid", {63'd0, valid_o}, 64'd1);
    rst = 1'b1;
    #1;
    check_val("async_rst_valid", {63'd0, valid_o}, 64'd0);
    check_val("async_rst_data", {32'd0, data_o}, 64'd0);
    exp_q.delete();
    expf_q.delete();
    acc_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check_val("post_rst_idle", {63'd0, valid_o}, 64'd0);
    send(va[3], vb[3], vr[3], vf[3]);
    drain();

    // half precision instance
    send_half(16'h3E00, 16'h4000, 16'h4200, 3'b000);
    send_half(16'h3C00, 16'h3C00, 16'h3C00, 3'b000);
    send_half(16'h7C00, 16'h0000, 16'h7E00, 3'b100);
    send_half(16'h7800, 16'h4000, 16'h7C00, 3'b010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
